// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_rr_arbiter_pkg
//   Shared definitions for the round-robin arbiter around the 8:1 output mux.
//   Holds the source count, the mux select width and type, and the
//   two-state controller encodings. The controller encodings are plain
//   logic constants so that older files can still compare against them.
package mux8_rr_arbiter_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/Mux_8.sv
// Mux_8
//   Existing 8:1 WIDTH-bit multiplexer with an active-low chip select.
//   The output is forced to zero while the mux is deselected.
//   Ports:
//     in1..in8  input   WIDTH  data inputs; addr 0 selects in1, addr 7 selects in8
//     addr      input   3      input select
//     nCS       input   1      chip select, active low
//     Mout      output  WIDTH  selected word, zero when nCS is high
module Mux_8
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  sel_t             addr,
  input  logic             nCS,
  output logic [WIDTH-1:0] Mout
);

  // Plain combinational select, gated by the chip select.
  always_comb begin
    Mout = '0;
    if (!nCS) begin
      case (addr)
        3'd0: Mout = in1;
        3'd1: Mout = in2;
        3'd2: Mout = in3;
        3'd3: Mout = in4;
        3'd4: Mout = in5;
        3'd5: Mout = in6;
        3'd6: Mout = in7;
        3'd7: Mout = in8;
      endcase
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter and sequencer for the shared 8-way output mux.
//   One requester holds the mux at a time. A tenure lasts while its request
//   stays high, up to MAX_BURST beats, and every tenure is followed by one
//   idle cycle in which the next requester is chosen.
//   Ports:
//     clk         input   1        rising-edge clock
//     rst_n       input   1        asynchronous active-low reset
//     req         input   8        request per source (bit i -> mux input i+1)
//     din         input   8*WIDTH  flattened sources, source i at din[i*WIDTH +: WIDTH]
//     gnt         output  8        one-hot grant, zero when idle
//     addr        output  3        mux select, index of the granted source
//     nCS         output  1        mux enable, low exactly while gnt != 0
//     dout        output  WIDTH    registered mux output
//     dout_valid  output  1        strobe, dout carries a new beat
//     busy        output  1        high while a grant is in progress
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*WIDTH-1:0] din,
  output logic [N_SRC-1:0]       gnt,
  output sel_t                   addr,
  output logic                   nCS,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic [0:0]       state;
  sel_t             ptr;
  sel_t             cur;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] mout;
  sel_t             pick;
  logic [N_SRC-1:0] pick_onehot;

  // Rotate the request vector so that ptr lands on bit 0, take the lowest
  // set bit, and rotate the index back. The source after the last one
  // served therefore has the highest priority.
  function automatic sel_t rr_pick(input logic [N_SRC-1:0] r, input sel_t p);
    logic [N_SRC-1:0] rot;
    sel_t             idx;
    logic             found;
    rot   = N_SRC'({r, r} >> p);
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && rot[i]) begin
        idx   = sel_t'(i);
        found = 1'b1;
      end
    end
    return idx + p;
  endfunction

  assign pick        = rr_pick(req, ptr);
  assign pick_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << pick;
  assign busy        = (state == GRANT);

  // addr and nCS come straight from registers, so during a grant the mux
  // output is already the current owner's word when the beat is captured.
  Mux_8 #(.WIDTH(WIDTH)) u_mux (
    .in1  (din[0*WIDTH +: WIDTH]),
    .in2  (din[1*WIDTH +: WIDTH]),
    .in3  (din[2*WIDTH +: WIDTH]),
    .in4  (din[3*WIDTH +: WIDTH]),
    .in5  (din[4*WIDTH +: WIDTH]),
    .in6  (din[5*WIDTH +: WIDTH]),
    .in7  (din[6*WIDTH +: WIDTH]),
    .in8  (din[7*WIDTH +: WIDTH]),
    .addr (addr),
    .nCS  (nCS),
    .Mout (mout)
  );

  // Controller. IDLE arbitrates among all requesters; GRANT only looks at
  // the owner's request. The tenure ends either when the owner drops its
  // request (no beat that cycle) or on the beat that reaches MAX_BURST, and
  // in both cases the pointer moves past the owner so it ranks last next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      addr       <= '0;
      nCS        <= 1'b1;
      ptr        <= '0;
      cur        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            cur   <= pick;
            gnt   <= pick_onehot;
            addr  <= pick;
            nCS   <= 1'b0;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (req[cur]) begin
            dout       <= mout;
            dout_valid <= 1'b1;
            cnt        <= cnt + 4'd1;
          end
          if (!req[cur] || (cnt + 4'd1 == BURST_LIM)) begin
            ptr   <= cur + sel_t'(1);
            gnt   <= '0;
            nCS   <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter
//   Self-checking bench for mux8_rr_arbiter. The main instance uses
//   MAX_BURST=4 and is followed by a transaction-level model of the
//   arbitration rules; a second instance with MAX_BURST=1 covers the
//   single-beat configuration.
module tb_mux8_rr_arbiter;

  localparam int MB = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  req   = '0;
  logic [63:0] din   = '0;
  logic [7:0]  gnt;
  logic [2:0]  addr;
  logic        nCS;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        busy;

  logic [7:0]  req1 = '0;
  logic [63:0] din1 = '0;
  logic [7:0]  gnt1;
  logic [2:0]  addr1;
  logic        nCS1;
  logic [7:0]  dout1;
  logic        dout_valid1;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  // Model state: who owns the mux (-1 = nobody), who has top priority next,
  // and how many beats the owner has had so far.
  int         m_owner;
  int         m_next;
  int         m_beats;
  logic [7:0] m_gnt;
  logic [2:0] m_addr;
  logic       m_ncs;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_busy;

  mux8_rr_arbiter #(.WIDTH(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt), .addr(addr),
    .nCS(nCS), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  mux8_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .din(din1), .gnt(gnt1), .addr(addr1),
    .nCS(nCS1), .dout(dout1), .dout_valid(dout_valid1), .busy(busy1)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Last-resort guard so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_owner = -1; m_next = 0; m_beats = 0;
    m_gnt = '0; m_addr = '0; m_ncs = 1'b1; m_dout = '0; m_valid = 1'b0; m_busy = 1'b0;
  endtask

  // One clock of the arbitration rules, applied to the inputs seen at the edge.
  task automatic model_step(input logic [7:0] r, input logic [63:0] d);
    logic found;
    m_valid = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_next + k) % 8]) begin
          m_owner = (m_next + k) % 8;
          found   = 1'b1;
        end
      end
      if (found) begin
        m_beats = 0;
        m_addr  = 3'(m_owner);
      end
    end else begin
      if (r[m_owner]) begin
        m_dout  = d[m_owner*8 +: 8];
        m_valid = 1'b1;
        m_beats = m_beats + 1;
      end
      if (!r[m_owner] || m_beats == MB) begin
        m_next  = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end
    m_gnt  = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    m_ncs  = (m_owner < 0);
    m_busy = (m_owner >= 0);
  endtask

  // Advance one clock edge and sample 1 ns later.
  task automatic tick();
    logic [7:0]  r;
    logic [63:0] d;
    r = req;
    d = din;
    @(posedge clk);
    if (rst_n) model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    req1  = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_gnt: got %h want 00", gnt); end
    checks++;
    if (addr !== 3'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", addr); end
    checks++;
    if (nCS !== 1'b1) begin errors++; $display("[TB] FAIL reset_ncs: got %b want 1", nCS); end
    checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_dout: got %h/%b want 00/0", dout, dout_valid);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    do_reset();
  endtask

  task automatic test_single();
    int strobes;
    do_reset();
    din[2*8 +: 8] = 8'hA5;
    req = 8'h04;
    tick();
    checks++;
    if (gnt !== 8'h04 || addr !== 3'd2 || nCS !== 1'b0) begin
      errors++; $display("[TB] FAIL single_grant: gnt=%h addr=%0d nCS=%b want 04/2/0", gnt, addr, nCS);
    end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dout_valid === 1'b1) strobes++;
      checks++;
      if (dout !== 8'hA5) begin errors++; $display("[TB] FAIL single_dout: got %h want a5", dout); end
    end
    checks++;
    if (strobes != 3) begin errors++; $display("[TB] FAIL single_strobes: got %0d want 3", strobes); end
    req = 8'h00;
    tick();
    checks++;
    if (gnt !== 8'h00 || nCS !== 1'b1 || dout_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_release: gnt=%h nCS=%b valid=%b want 00/1/0", gnt, nCS, dout_valid);
    end
  endtask

  task automatic test_contention();
    int tenure, beats, gap;
    logic [7:0] prev;
    do_reset();
    din = {$urandom, $urandom};
    req = 8'hFF;
    tenure = 0; beats = 0; gap = 0; prev = 8'h00;
    for (int c = 0; c < 60 && tenure < 9; c++) begin
      tick();
      checks++;
      if ({gnt, addr, nCS, dout, dout_valid} !== {m_gnt, m_addr, m_ncs, m_dout, m_valid}) begin
        errors++;
        $display("[TB] FAIL contention_model: gnt=%h addr=%0d nCS=%b dout=%h v=%b want %h/%0d/%b/%h/%b",
                 gnt, addr, nCS, dout, dout_valid, m_gnt, m_addr, m_ncs, m_dout, m_valid);
      end
      if (gnt !== 8'h00 && prev === 8'h00) begin
        if (tenure > 0) begin
          checks++;
          if (beats != MB) begin errors++; $display("[TB] FAIL contention_beats: got %0d want %0d", beats, MB); end
          checks++;
          if (gap != 1) begin errors++; $display("[TB] FAIL contention_gap: got %0d want 1", gap); end
        end
        checks++;
        if (addr !== 3'(tenure % 8)) begin
          errors++; $display("[TB] FAIL contention_order: got %0d want %0d", addr, tenure % 8);
        end
        tenure++; beats = 0; gap = 0;
      end
      if (dout_valid === 1'b1) beats++;
      if (gnt === 8'h00) gap++;
      prev = gnt;
    end
    checks++;
    if (tenure != 9) begin errors++; $display("[TB] FAIL contention_count: got %0d want 9", tenure); end
  endtask

  task automatic test_wrap();
    int found;
    do_reset();
    req = 8'h80;
    tick();
    checks++;
    if (gnt !== 8'h80) begin errors++; $display("[TB] FAIL wrap_first: got %h want 80", gnt); end
    tick();
    req = 8'h00;
    tick();
    req = 8'h81;
    tick();
    checks++;
    if (gnt !== 8'h01) begin errors++; $display("[TB] FAIL wrap_src0: got %h want 01", gnt); end
    found = 0;
    for (int c = 0; c < 12 && found == 0; c++) begin
      tick();
      if (gnt !== 8'h00 && gnt !== 8'h01) found = 1;
    end
    checks++;
    if (found == 0 || gnt !== 8'h80) begin errors++; $display("[TB] FAIL wrap_src7: got %h want 80", gnt); end
  endtask

  task automatic test_early_release();
    logic [7:0] d3;
    int strobes;
    do_reset();
    d3 = 8'($urandom) | 8'h01;
    din[3*8 +: 8] = d3;
    req = 8'h08;
    strobes = 0;
    tick();
    checks++;
    if (gnt !== 8'h08) begin errors++; $display("[TB] FAIL early_grant: got %h want 08", gnt); end
    tick();
    if (dout_valid === 1'b1) strobes++;
    req = 8'h00;
    din[3*8 +: 8] = ~d3;
    tick();
    if (dout_valid === 1'b1) strobes++;
    checks++;
    if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL early_release: got %h want 00", gnt); end
    tick();
    if (dout_valid === 1'b1) strobes++;
    checks++;
    if (dout !== d3) begin errors++; $display("[TB] FAIL early_hold: got %h want %h", dout, d3); end
    checks++;
    if (strobes != 1) begin errors++; $display("[TB] FAIL early_strobes: got %0d want 1", strobes); end
    req = 8'h18;
    tick();
    checks++;
    if (gnt !== 8'h10) begin errors++; $display("[TB] FAIL early_ptr: got %h want 10", gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    din[5*8 +: 8] = 8'($urandom) | 8'h80;
    req = 8'h20;
    tick();
    tick();
    checks++;
    if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_beat1: got %b want 1", dout_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || nCS !== 1'b1 || dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_async: gnt=%h nCS=%b dout=%h v=%b busy=%b want 00/1/00/0/0",
                         gnt, nCS, dout, dout_valid, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (gnt !== 8'h20 || addr !== 3'd5) begin
      errors++; $display("[TB] FAIL midrst_regrant: gnt=%h addr=%0d want 20/5", gnt, addr);
    end
  endtask

  task automatic test_burst1();
    logic [7:0] s0, s1;
    do_reset();
    s0 = 8'($urandom);
    s1 = 8'($urandom);
    din1 = {48'h0, s1, s0};
    req1 = 8'h03;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (c % 2 == 0) begin
        if (gnt1 !== 8'(1 << ((c / 2) % 2)) || dout_valid1 !== 1'b0) begin
          errors++; $display("[TB] FAIL burst1_grant: gnt=%h v=%b want %h/0", gnt1, dout_valid1, 8'(1 << ((c / 2) % 2)));
        end
      end else begin
        if (gnt1 !== 8'h00 || dout_valid1 !== 1'b1 || dout1 !== (((c / 2) % 2) == 0 ? s0 : s1)) begin
          errors++; $display("[TB] FAIL burst1_beat: gnt=%h v=%b dout=%h", gnt1, dout_valid1, dout1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [21:0] act, exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: req = 8'($urandom);
        3:       req = 8'h00;
        4:       if (m_owner >= 0) req[m_owner] = 1'b0;
        default: ;
      endcase
      din = {$urandom, $urandom};
      tick();
      act = {gnt, addr, nCS, dout, dout_valid, busy};
      exp = {m_gnt, m_addr, m_ncs, m_dout, m_valid, m_busy};
      checks++;
      if (act !== exp) begin
        errors++; $display("[TB] FAIL random_cycle%0d: got %h want %h", c, act, exp);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_early_release();
    test_reset_mid();
    test_burst1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
